led_bus_arbiter: RTL and testbench
==================================

Name: led_bus_arbiter

Overview:
Arbitrates the board LED bank between CPU memory-mapped LED writes and a hardware debug/status requester (e.g. exception reporter). The block sits between the MMIO decoder and the LED driver, and produces the single write strobe, address and data the LED driver consumes. While debug owns the LEDs, CPU writes are captured in shadow registers. When debug releases, the shadow contents are replayed so the CPU's view of the LEDs is restored.

Parameters:
HOLD_CYCLES, 16, minimum number of cycles debug keeps ownership after its last write (must be >=1).
CNT_W, 8, width of the hold counter (HOLD_CYCLES < 2**CNT_W).

Ports:
iCpuClock  input  1  system clock
iCpuReset  input  1  asynchronous active-high reset
iCpuLedWrite  input  1  CPU LED write strobe, one cycle per write
iCpuLedAddress  input  2  CPU LED address: 00 = low 16 LEDs, 10 = high 8 LEDs, others invalid
iCpuLedData  input  16  CPU write data
iDbgReq  input  1  debug requests LED ownership (level)
iDbgWrite  input  1  debug write strobe, honoured only while oDbgGrant=1
iDbgAddress  input  2  debug LED address, same encoding as the CPU address
iDbgData  input  16  debug write data
oDbgGrant  output  1  debug owns the LEDs
oDoLedWrite  output  1  write strobe to the LED driver
oLightAddress  output  2  address to the LED driver
oLightDataToWrite  output  16  data to the LED driver
oCpuShadowPending  output  1  CPU writes are waiting to be replayed
oOwner  output  1  0 = CPU path, 1 = debug

Behaviour:
- Reset is asynchronous and active-high on iCpuReset; all logic is clocked on the rising edge of iCpuClock.
- Reset values:
  - all outputs 0.
  - state IDLE.
  - shadowLo = 16'h0000, shadowHi = 8'h00.
  - dirty = 0, redo = 0, counter = 0.
- All outputs are registered. A write accepted at edge N appears on oDoLedWrite/oLightAddress/oLightDataToWrite for exactly one cycle after edge N.
- A CPU write with address 00 or 10 always updates shadowLo or shadowHi (data[7:0] for address 10), in every state. Addresses 01 and 11 are ignored everywhere and never forwarded.
- IDLE:
  - A valid CPU write with iDbgReq=0 is forwarded.
  - If iDbgReq=1, go to DBG_HOLD: oDbgGrant=1, oOwner=1, counter=HOLD_CYCLES.
  - A CPU write in that same cycle is shadowed only, not forwarded, and sets dirty=1. Debug wins all ties.
- DBG_HOLD:
  - A debug write with a valid address is forwarded; address 10 sends {8'h00, data[7:0]}. Each debug write reloads counter=HOLD_CYCLES.
  - Otherwise the counter decrements, saturating at 0.
  - CPU writes set dirty=1 and are not forwarded.
  - Exit when counter==0 and iDbgReq==0: oDbgGrant falls on that edge, then go to REPLAY_LO. Debug writes received after grant drop are ignored.
- REPLAY_LO: issue a write with address 00 and shadowLo; go to REPLAY_HI.
- REPLAY_HI:
  - Issue a write with address 10 and {8'h00, shadowHi}.
  - If redo=1, clear redo and go to REPLAY_LO; else clear dirty and go to IDLE.
- CPU writes during REPLAY_LO or REPLAY_HI update the shadow registers and set redo=1. They are never forwarded directly.
- Replay is not preemptible. iDbgReq is sampled again only in IDLE.
- Replay always restores both halves, regardless of which half was written.
- oCpuShadowPending equals dirty.
- Reset mid-replay or mid-hold: everything returns to reset values immediately and no write is emitted.

Optional Feature:
Macro LED_SHADOW_REPLAY_EN.
- Defined: replay behaviour as described above.
- Undefined:
  - REPLAY states are absent; DBG_HOLD exits directly to IDLE.
  - CPU writes during DBG_HOLD are dropped.
  - oCpuShadowPending is tied to 0.
  - Shadow registers are not implemented.

Test Plan:
- After reset, CPU writes address 00 / 16'hA5A5 with no debug -> one cycle later oDoLedWrite=1, address 00, data A5A5, for exactly one cycle.
- Debug requests, writes address 10 / 16'h003C, then drops the request, with HOLD_CYCLES=4 -> forwarded as 10 / 003C; oDbgGrant stays high for 4 cycles after that write, then falls.
- CPU writes 00 / 1234 and 10 / 0056 during the hold; debug releases -> replay writes 00 / 1234, then 10 / 0056, on consecutive cycles; oCpuShadowPending is 1 during the hold and 0 after the replay.
- CPU write and debug request in the same IDLE cycle -> no CPU forward, grant asserted, CPU data replayed after release.
- CPU writes 00 / BEEF during REPLAY_HI -> a second replay pair follows with low half BEEF.
- CPU writes to address 01 -> no output write and no change to the shadow registers.
- Reset asserted mid-hold -> all outputs 0 immediately; subsequent CPU writes forward normally.

Source files
------------

// File: rtl/led_bus_arbiter_if.sv
// LED bus bundle between the MMIO/debug side (master) and led_bus_arbiter (slave).
interface led_bus_arbiter_if;
    logic        iCpuLedWrite;
    logic [1:0]  iCpuLedAddress;
    logic [15:0] iCpuLedData;
    logic        iDbgReq;
    logic        iDbgWrite;
    logic [1:0]  iDbgAddress;
    logic [15:0] iDbgData;
    logic        oDbgGrant;
    logic        oDoLedWrite;
    logic [1:0]  oLightAddress;
    logic [15:0] oLightDataToWrite;
    logic        oCpuShadowPending;
    logic        oOwner;

    modport master (
        output iCpuLedWrite, iCpuLedAddress, iCpuLedData,
        output iDbgReq, iDbgWrite, iDbgAddress, iDbgData,
        input  oDbgGrant, oDoLedWrite, oLightAddress, oLightDataToWrite,
        input  oCpuShadowPending, oOwner
    );

    modport slave (
        input  iCpuLedWrite, iCpuLedAddress, iCpuLedData,
        input  iDbgReq, iDbgWrite, iDbgAddress, iDbgData,
        output oDbgGrant, oDoLedWrite, oLightAddress, oLightDataToWrite,
        output oCpuShadowPending, oOwner
    );
endinterface

// File: rtl/led_bus_arbiter.sv
// Arbitrates the LED bank between CPU MMIO writes and a debug requester.
// Define LED_SHADOW_REPLAY_EN to shadow CPU writes during debug ownership and replay them on release.
module led_bus_arbiter #(
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic             iCpuClock,
    input  logic             iCpuReset,
    led_bus_arbiter_if.slave bus
);

`ifdef LED_SHADOW_REPLAY_EN
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        DBG_HOLD  = 2'b01,
        REPLAY_LO = 2'b10,
        REPLAY_HI = 2'b11
    } state_e;
`else
    typedef enum logic {
        IDLE     = 1'b0,
        DBG_HOLD = 1'b1
    } state_e;
`endif

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
    localparam logic [1:0]       ADDR_LO   = 2'b00;
    localparam logic [1:0]       ADDR_HI   = 2'b10;

    // The high bank has only 8 LEDs, so its upper data byte is always driven as zero.
    function automatic logic [15:0] led_payload(input logic [1:0] addr, input logic [15:0] data);
        if (addr == ADDR_HI) begin
            return {8'h00, data[7:0]};
        end else begin
            return data;
        end
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic             grant_q, grant_d;
    logic             owner_q, owner_d;
    logic             wr_q, wr_d;
    logic [1:0]       addr_q, addr_d;
    logic [15:0]      data_q, data_d;
    logic             cpu_valid;
    logic             dbg_write;
    logic             dbg_addr_ok;

    assign cpu_valid   = bus.iCpuLedWrite &&
                         ((bus.iCpuLedAddress == ADDR_LO) || (bus.iCpuLedAddress == ADDR_HI));
    assign dbg_write   = bus.iDbgWrite && grant_q;
    assign dbg_addr_ok = (bus.iDbgAddress == ADDR_LO) || (bus.iDbgAddress == ADDR_HI);

`ifdef LED_SHADOW_REPLAY_EN
    logic [15:0] shadow_lo_q;
    logic [7:0]  shadow_hi_q;
    logic        dirty_q, dirty_d;
    logic        redo_q, redo_d;

    // Shadow copy of every valid CPU write, whatever the current owner.
    always_ff @(posedge iCpuClock or posedge iCpuReset) begin
        if (iCpuReset) begin
            shadow_lo_q <= 16'h0000;
            shadow_hi_q <= 8'h00;
        end else if (bus.iCpuLedWrite && (bus.iCpuLedAddress == ADDR_LO)) begin
            shadow_lo_q <= bus.iCpuLedData;
        end else if (bus.iCpuLedWrite && (bus.iCpuLedAddress == ADDR_HI)) begin
            shadow_hi_q <= bus.iCpuLedData[7:0];
        end
    end

    // Replay bookkeeping flags.
    always_ff @(posedge iCpuClock or posedge iCpuReset) begin
        if (iCpuReset) begin
            dirty_q <= 1'b0;
            redo_q  <= 1'b0;
        end else begin
            dirty_q <= dirty_d;
            redo_q  <= redo_d;
        end
    end

    assign bus.oCpuShadowPending = dirty_q;
`else
    assign bus.oCpuShadowPending = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        wr_d      = 1'b0;
        addr_d    = 2'b00;
        data_d    = 16'h0000;
`ifdef LED_SHADOW_REPLAY_EN
        dirty_d   = dirty_q;
        redo_d    = redo_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.iDbgReq) begin
                    // Debug wins ties; a coincident CPU write only lands in the shadow.
                    state_d   = DBG_HOLD;
                    grant_d   = 1'b1;
                    owner_d   = 1'b1;
                    counter_d = HOLD_LOAD;
`ifdef LED_SHADOW_REPLAY_EN
                    if (cpu_valid) begin
                        dirty_d = 1'b1;
                    end else begin
                        dirty_d = dirty_q;
                    end
`endif
                end else if (cpu_valid) begin
                    wr_d   = 1'b1;
                    addr_d = bus.iCpuLedAddress;
                    data_d = led_payload(bus.iCpuLedAddress, bus.iCpuLedData);
                end else begin
                    state_d = IDLE;
                end
            end
            DBG_HOLD: begin
`ifdef LED_SHADOW_REPLAY_EN
                if (cpu_valid) begin
                    dirty_d = 1'b1;
                end else begin
                    dirty_d = dirty_q;
                end
`endif
                if (dbg_write) begin
                    counter_d = HOLD_LOAD;
                    if (dbg_addr_ok) begin
                        wr_d   = 1'b1;
                        addr_d = bus.iDbgAddress;
                        data_d = led_payload(bus.iDbgAddress, bus.iDbgData);
                    end else begin
                        wr_d = 1'b0;
                    end
                end else if ((counter_q == '0) && !bus.iDbgReq) begin
                    grant_d = 1'b0;
                    owner_d = 1'b0;
`ifdef LED_SHADOW_REPLAY_EN
                    state_d = REPLAY_LO;
`else
                    state_d = IDLE;
`endif
                end else if (counter_q != '0) begin
                    counter_d = counter_q - CNT_W'(1);
                end else begin
                    counter_d = counter_q;
                end
            end
`ifdef LED_SHADOW_REPLAY_EN
            REPLAY_LO: begin
                wr_d    = 1'b1;
                addr_d  = ADDR_LO;
                data_d  = shadow_lo_q;
                state_d = REPLAY_HI;
                if (cpu_valid) begin
                    redo_d  = 1'b1;
                    dirty_d = 1'b1;
                end else begin
                    redo_d = redo_q;
                end
            end
            REPLAY_HI: begin
                wr_d   = 1'b1;
                addr_d = ADDR_HI;
                data_d = {8'h00, shadow_hi_q};
                // A CPU write landing now is already in the shadow, so it joins the next pass.
                if (redo_q || cpu_valid) begin
                    redo_d  = 1'b0;
                    dirty_d = 1'b1;
                    state_d = REPLAY_LO;
                end else begin
                    dirty_d = 1'b0;
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d   = IDLE;
                grant_d   = 1'b0;
                owner_d   = 1'b0;
                counter_d = '0;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge iCpuClock or posedge iCpuReset) begin
        if (iCpuReset) begin
            state_q   <= IDLE;
            counter_q <= '0;
            grant_q   <= 1'b0;
            owner_q   <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= 2'b00;
            data_q    <= 16'h0000;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    assign bus.oDbgGrant         = grant_q;
    assign bus.oOwner            = owner_q;
    assign bus.oDoLedWrite       = wr_q;
    assign bus.oLightAddress     = addr_q;
    assign bus.oLightDataToWrite = data_q;

endmodule

// File: tb/tb_led_bus_arbiter.sv
// Directed bench for led_bus_arbiter with HOLD_CYCLES=4; expectations follow LED_SHADOW_REPLAY_EN.
module tb_led_bus_arbiter;

`ifdef LED_SHADOW_REPLAY_EN
    localparam logic [15:0] PEND = 16'h0001;
`else
    localparam logic [15:0] PEND = 16'h0000;
`endif

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    led_bus_arbiter_if bus ();

    led_bus_arbiter #(
        .HOLD_CYCLES(4),
        .CNT_W      (8)
    ) dut (
        .iCpuClock(clk),
        .iCpuReset(rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cpu(input logic wr, input logic [1:0] addr, input logic [15:0] data);
        bus.iCpuLedWrite   = wr;
        bus.iCpuLedAddress = addr;
        bus.iCpuLedData    = data;
    endtask

    task automatic dbg(input logic wr, input logic [1:0] addr, input logic [15:0] data);
        bus.iDbgWrite   = wr;
        bus.iDbgAddress = addr;
        bus.iDbgData    = data;
    endtask

    task automatic check_wr(input string tag, input logic [1:0] addr, input logic [15:0] data);
        check({tag, "_wr"}, {15'd0, bus.oDoLedWrite}, 16'h0001);
        check({tag, "_addr"}, {14'd0, bus.oLightAddress}, {14'd0, addr});
        check({tag, "_data"}, bus.oLightDataToWrite, data);
    endtask

    task automatic check_nowr(input string tag);
        check(tag, {15'd0, bus.oDoLedWrite}, 16'h0000);
    endtask

    initial begin
        rst = 1'b1;
        bus.iDbgReq = 1'b0;
        cpu(1'b0, 2'b00, 16'h0000);
        dbg(1'b0, 2'b00, 16'h0000);
        step();
        step();
        check("rst_grant", {15'd0, bus.oDbgGrant}, 16'h0000);
        check("rst_wr", {15'd0, bus.oDoLedWrite}, 16'h0000);
        check("rst_addr", {14'd0, bus.oLightAddress}, 16'h0000);
        check("rst_data", bus.oLightDataToWrite, 16'h0000);
        check("rst_pend", {15'd0, bus.oCpuShadowPending}, 16'h0000);
        check("rst_owner", {15'd0, bus.oOwner}, 16'h0000);
        rst = 1'b0;

        // Plain CPU forward, one-cycle strobe.
        cpu(1'b1, 2'b00, 16'hA5A5);
        step();
        check_wr("cpu_fwd", 2'b00, 16'hA5A5);
        cpu(1'b0, 2'b00, 16'h0000);
        step();
        check_nowr("cpu_fwd_one_cycle");

        // Invalid address never forwarded.
        cpu(1'b1, 2'b01, 16'hFFFF);
        step();
        check_nowr("cpu_addr01");
        cpu(1'b0, 2'b00, 16'h0000);
        step();

        // Debug hold with CPU writes shadowed.
        bus.iDbgReq = 1'b1;
        step();
        check("hold_grant", {15'd0, bus.oDbgGrant}, 16'h0001);
        check("hold_owner", {15'd0, bus.oOwner}, 16'h0001);
        check_nowr("hold_enter_nowr");
        dbg(1'b1, 2'b10, 16'h003C);
        step();
        check_wr("dbg_fwd", 2'b10, 16'h003C);
        dbg(1'b0, 2'b00, 16'h0000);
        bus.iDbgReq = 1'b0;
        cpu(1'b1, 2'b00, 16'h1234);
        step();
        check_nowr("hold_cpu_lo_nofwd");
        check("hold_pend", {15'd0, bus.oCpuShadowPending}, PEND);
        cpu(1'b1, 2'b10, 16'h0056);
        step();
        check_nowr("hold_cpu_hi_nofwd");
        cpu(1'b1, 2'b01, 16'h9999);
        step();
        check("hold_grant_w3", {15'd0, bus.oDbgGrant}, 16'h0001);
        cpu(1'b0, 2'b00, 16'h0000);
        step();
        check("hold_grant_w4", {15'd0, bus.oDbgGrant}, 16'h0001);
        step();
        check("hold_release", {15'd0, bus.oDbgGrant}, 16'h0000);
        check("hold_owner_rel", {15'd0, bus.oOwner}, 16'h0000);
        check_nowr("hold_release_nowr");
        dbg(1'b1, 2'b00, 16'hFFFF);
`ifdef LED_SHADOW_REPLAY_EN
        step();
        check_wr("replay_lo", 2'b00, 16'h1234);
        dbg(1'b0, 2'b00, 16'h0000);
        step();
        check_wr("replay_hi", 2'b10, 16'h0056);
        step();
        check_nowr("replay_done");
        check("replay_pend_clr", {15'd0, bus.oCpuShadowPending}, 16'h0000);
`else
        step();
        check_nowr("late_dbg_ignored");
        dbg(1'b0, 2'b00, 16'h0000);
        step();
        check_nowr("no_replay");
`endif

        // CPU write tied with debug request: debug wins.
        cpu(1'b1, 2'b00, 16'h4321);
        bus.iDbgReq = 1'b1;
        step();
        check_nowr("tie_nofwd");
        check("tie_grant", {15'd0, bus.oDbgGrant}, 16'h0001);
        check("tie_pend", {15'd0, bus.oCpuShadowPending}, PEND);
        cpu(1'b0, 2'b00, 16'h0000);
        bus.iDbgReq = 1'b0;
        step();
        step();
        step();
        step();
        check("tie_grant_hold", {15'd0, bus.oDbgGrant}, 16'h0001);
        step();
        check("tie_release", {15'd0, bus.oDbgGrant}, 16'h0000);
`ifdef LED_SHADOW_REPLAY_EN
        step();
        check_wr("tie_replay_lo", 2'b00, 16'h4321);
        cpu(1'b1, 2'b00, 16'hBEEF);
        step();
        check_wr("tie_replay_hi", 2'b10, 16'h0056);
        cpu(1'b0, 2'b00, 16'h0000);
        step();
        check_wr("redo_lo", 2'b00, 16'hBEEF);
        step();
        check_wr("redo_hi", 2'b10, 16'h0056);
        step();
        check_nowr("redo_done");
        check("redo_pend_clr", {15'd0, bus.oCpuShadowPending}, 16'h0000);
`else
        step();
        check_nowr("tie_no_replay");
`endif

        // Asynchronous reset in the middle of a hold.
        bus.iDbgReq = 1'b1;
        step();
        check("mid_grant", {15'd0, bus.oDbgGrant}, 16'h0001);
        dbg(1'b1, 2'b00, 16'h7777);
        cpu(1'b1, 2'b00, 16'h1111);
        step();
        check_wr("mid_dbg_fwd", 2'b00, 16'h7777);
        check("mid_pend", {15'd0, bus.oCpuShadowPending}, PEND);
        rst = 1'b1;
        #1;
        check("arst_wr", {15'd0, bus.oDoLedWrite}, 16'h0000);
        check("arst_grant", {15'd0, bus.oDbgGrant}, 16'h0000);
        check("arst_owner", {15'd0, bus.oOwner}, 16'h0000);
        check("arst_data", bus.oLightDataToWrite, 16'h0000);
        check("arst_pend", {15'd0, bus.oCpuShadowPending}, 16'h0000);
        bus.iDbgReq = 1'b0;
        dbg(1'b0, 2'b00, 16'h0000);
        cpu(1'b0, 2'b00, 16'h0000);
        step();
        rst = 1'b0;
        cpu(1'b1, 2'b00, 16'h0F0F);
        step();
        check_wr("post_rst_fwd", 2'b00, 16'h0F0F);
        cpu(1'b0, 2'b00, 16'h0000);
        step();
        check_nowr("post_rst_one_cycle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
